ps2_scancode_rx: RTL and testbench

- Upstream stage of the keyboard LED toggle logic.
- Receives raw PS/2 device-to-host frames on ps2_clk/ps2_data and produces the 8-bit scancode bus check_code with a one-cycle strobe code_new_updated; both feed the LED state machine directly.
- Also flags malformed frames so the downstream logic never sees a corrupted code.

---
 rtl/ps2_scancode_rx_if.sv | 22 ++
 rtl/ps2_scancode_rx.sv | 199 +++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_if.sv
// Scancode bus from the PS/2 receiver to the keyboard LED state machine.
// The receiver drives it through the master modport; the LED logic observes it through slave.
interface ps2_scancode_rx_if;
  logic [7:0] check_code;
  logic       code_new_updated;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output check_code,
    output code_new_updated,
    output parity_err,
    output frame_err
  );

  modport slave (
    input check_code,
    input code_new_updated,
    input parity_err,
    input frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the line,
// deframes 11-bit frames and publishes good scancodes or one-cycle error pulses.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic               clk_2,
  input  logic               rst_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_scancode_rx_if.master  code_if
);

  localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic       clk_meta_r;
  logic       clk_sync_r;
  logic       data_meta_r;
  logic       data_sync_r;
  logic       filt_clk_r;
  logic       filt_prev_r;
  logic [7:0] filt_cnt_r;
  logic       fall_s;

  state_t      state_r;
  state_t      state_n;
  logic [2:0]  bit_cnt_r;
  logic [2:0]  bit_cnt_n;
  logic [7:0]  shift_r;
  logic [7:0]  shift_n;
  logic        par_r;
  logic        par_n;
  logic [15:0] tmo_cnt_r;
  logic [15:0] tmo_n;
  logic [7:0]  check_code_r;
  logic [7:0]  check_code_n;
  logic        code_new_r;
  logic        code_new_n;
  logic        parity_err_r;
  logic        parity_err_n;
  logic        frame_err_r;
  logic        frame_err_n;

  // Two-stage synchronizers for the asynchronous connector lines (idle high).
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: the filtered clock follows only a level held for FILTER_LEN cycles.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= 8'd0;
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_sync_r != filt_clk_r) begin
        if (filt_cnt_r == FILT_LAST) begin
          filt_clk_r <= clk_sync_r;
          filt_cnt_r <= 8'd0;
        end else begin
          filt_cnt_r <= filt_cnt_r + 8'd1;
        end
      end else begin
        filt_cnt_r <= 8'd0;
      end
    end
  end

  assign fall_s = filt_prev_r & ~filt_clk_r;

  // Frame state, shift register, timeout counter and registered outputs.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'd0;
      par_r        <= 1'b0;
      tmo_cnt_r    <= 16'd0;
      check_code_r <= 8'd0;
      code_new_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_n;
      bit_cnt_r    <= bit_cnt_n;
      shift_r      <= shift_n;
      par_r        <= par_n;
      tmo_cnt_r    <= tmo_n;
      check_code_r <= check_code_n;
      code_new_r   <= code_new_n;
      parity_err_r <= parity_err_n;
      frame_err_r  <= frame_err_n;
    end
  end

  // Next-state and output decode; a falling edge always wins over timeout expiry.
  always_comb begin
    state_n      = state_r;
    bit_cnt_n    = bit_cnt_r;
    shift_n      = shift_r;
    par_n        = par_r;
    tmo_n        = tmo_cnt_r;
    check_code_n = check_code_r;
    code_new_n   = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (fall_s && !data_sync_r) begin
          state_n   = ST_DATA;
          bit_cnt_n = 3'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_n   = {data_sync_r, shift_r[7:1]};
          bit_cnt_n = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_n = ST_PARITY;
          end else begin
            state_n = ST_DATA;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          par_n   = data_sync_r;
          state_n = ST_STOP;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_n = ST_IDLE;
          if (!data_sync_r) begin
            frame_err_n = 1'b1;
          end else if (!odd_parity_ok(shift_r, par_r)) begin
            parity_err_n = 1'b1;
          end else begin
            check_code_n = shift_r;
            code_new_n   = 1'b1;
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Pulses above only fire on an edge, so a timeout pulse can never collide with them.
    if ((state_r == ST_IDLE) || fall_s) begin
      tmo_n = 16'd0;
    end else if (tmo_cnt_r >= TMO_LAST) begin
      state_n     = ST_IDLE;
      frame_err_n = 1'b1;
      tmo_n       = 16'd0;
    end else begin
      tmo_n = tmo_cnt_r + 16'd1;
    end
  end

  assign code_if.check_code       = check_code_r;
  assign code_if.code_new_updated = code_new_r;
  assign code_if.parity_err       = parity_err_r;
  assign code_if.frame_err        = frame_err_r;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: stimulus queues expected pulses, a monitor checks them.
// The PS/2 bit rate is compressed (80 clk_2 cycles per bit) to keep the run short.
module tb_ps2_scancode_rx;
  localparam int HALF        = 40;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 20000;
  localparam int K_CODE      = 0;
  localparam int K_PARITY    = 1;
  localparam int K_FRAME     = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    int         stamp;
  } exp_t;

  logic clk_2    = 1'b0;
  logic rst_n    = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         mon_np;
  int         mon_kind;
  int         mon_lat;
  logic [7:0] last_good   = 8'h00;

  ps2_scancode_rx_if rx_if();

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_2    (clk_2),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code_if  (rx_if)
  );

  always #10 clk_2 = ~clk_2;

  always @(posedge clk_2) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // Sends the first nbits of a frame; optional 3-cycle low glitch in the high phase before glitch_bit.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit,
                           input int exp_kind, input logic [7:0] exp_code);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 13);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      if (i == 10 && exp_kind >= 0) sb_q.push_back('{exp_kind, exp_code, cyc});
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input logic s,
                       input int glitch_bit, input int kind);
    logic [7:0] exp_code;
    exp_code = (kind == K_CODE) ? d : last_good;
    send_bits(mk(d, p, s), 11, glitch_bit, kind, exp_code);
    if (kind == K_CODE) last_good = d;
    ps2_data = 1'b1;
  endtask

  // Monitor: every output pulse is matched against the head of the scoreboard.
  always @(negedge clk_2) begin
    if (rst_n) begin
      mon_np = int'(rx_if.code_new_updated) + int'(rx_if.parity_err) + int'(rx_if.frame_err);
      if (mon_np != 0) begin
        check("pulse_onehot", mon_np, 1);
        mon_kind = rx_if.code_new_updated ? K_CODE : (rx_if.parity_err ? K_PARITY : K_FRAME);
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got kind %0d code 0x%0h, expected no pulse (cycle %0d)",
                   mon_kind, rx_if.check_code, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("pulse_kind", mon_kind, mon_e.kind);
          check("check_code", rx_if.check_code, mon_e.code);
          if (mon_e.stamp >= 0) begin
            mon_lat = cyc - mon_e.stamp;
            vectors++;
            if (mon_lat < FILTER_LEN + 2 || mon_lat > FILTER_LEN + 4) begin
              miscompares++;
              $display("FAIL latency: got %0d cycles, expected %0d..%0d",
                       mon_lat, FILTER_LEN + 2, FILTER_LEN + 4);
            end
          end
        end
      end
    end
  end

  initial begin
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    check("rst_check_code", rx_if.check_code, 8'h00);
    check("rst_code_new", rx_if.code_new_updated, 1'b0);
    check("rst_parity_err", rx_if.parity_err, 1'b0);
    check("rst_frame_err", rx_if.frame_err, 1'b0);

    frame(8'h7E, 1'b1, 1'b1, -1, K_CODE);
    wait_cyc(100);

    frame(8'hF0, 1'b1, 1'b1, -1, K_CODE);
    frame(8'h1C, 1'b0, 1'b1, -1, K_CODE);
    wait_cyc(100);

    frame(8'h7E, 1'b0, 1'b1, -1, K_PARITY);
    wait_cyc(100);

    frame(8'h7E, 1'b1, 1'b0, -1, K_FRAME);
    wait_cyc(100);

    // Start bit plus four data bits, then the line goes quiet until the timeout fires.
    sb_q.push_back('{K_FRAME, last_good, -1});
    send_bits(mk(8'h7E, 1'b1, 1'b1), 5, -1, -1, 8'h00);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT_CYC + 200);
    frame(8'h7E, 1'b1, 1'b1, -1, K_CODE);
    wait_cyc(100);

    // Idle glitch with data low would start a bogus frame if it leaked through the filter.
    ps2_data = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(50);
    frame(8'hF0, 1'b1, 1'b1, 4, K_CODE);
    wait_cyc(100);

    send_bits(mk(8'h7E, 1'b1, 1'b1), 6, -1, -1, 8'h00);
    rst_n = 1'b0;
    #1;
    check("midrst_check_code", rx_if.check_code, 8'h00);
    check("midrst_code_new", rx_if.code_new_updated, 1'b0);
    check("midrst_parity_err", rx_if.parity_err, 1'b0);
    check("midrst_frame_err", rx_if.frame_err, 1'b0);
    last_good = 8'h00;
    wait_cyc(3);
    rst_n    = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(50);
    frame(8'h7E, 1'b1, 1'b1, -1, K_CODE);

    wait_cyc(200);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
